// File: rtl/display_scheduler_if.sv
// Bus between the world-clock face logic and the display scheduler.
// The master is the clock/decoder side; the slave is the scheduler itself.
interface display_scheduler_if;
  logic       refresh;
  logic [6:0] sec;
  logic [6:0] min;
  logic [6:0] hr;
  logic [6:0] zone;
  logic [3:0] blink_mask;
  logic       blink_phase;
  logic [6:0] dec_value;
  logic [7:0] dec_left;
  logic [7:0] dec_right;
  logic [63:0] seg;
  logic       busy;
  logic       frame_done;

  modport master (
    output refresh, sec, min, hr, zone, blink_mask, blink_phase, dec_left, dec_right,
    input  dec_value, seg, busy, frame_done
  );

  modport slave (
    input  refresh, sec, min, hr, zone, blink_mask, blink_phase, dec_left, dec_right,
    output dec_value, seg, busy, frame_done
  );
endinterface

// File: rtl/display_scheduler.sv
// Time-shares one two-digit seven-segment decoder across the four clock fields
// and assembles the results, with overlays, into a 64-bit segment bank.
module display_scheduler #(
  parameter logic [3:0] LZ_BLANK_MASK = 4'b0100,
  parameter logic [3:0] DP_MASK       = 4'b0000
) (
  input logic                hz100,
  input logic                reset_n,
  display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  slot_reg, slot_next;
  logic        pending_reg, pending_next;
  logic        busy_reg, busy_next;
  logic        frame_done_reg, frame_done_next;
  logic [6:0]  dec_value_reg, dec_value_next;
  logic [6:0]  snap_reg [4];
  logic [15:0] seg_slot_reg [4];
  logic [6:0]  field [4];
  logic        snap_load;
  logic        seg_we;
  logic [6:0]  cur_value;
  logic [7:0]  pair_left, pair_right;
  logic [63:0] seg_flat;

  assign field[0] = bus.sec;
  assign field[1] = bus.min;
  assign field[2] = bus.hr;
  assign field[3] = bus.zone;

  always_ff @(posedge hz100) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      slot_reg       <= 2'd0;
      pending_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      dec_value_reg  <= 7'd0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      pending_reg    <= pending_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      dec_value_reg  <= dec_value_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    slot_next       = slot_reg;
    pending_next    = pending_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    dec_value_next  = dec_value_reg;
    snap_load       = 1'b0;
    seg_we          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.refresh || pending_reg) begin
          snap_load    = 1'b1;
          pending_next = 1'b0;
          slot_next    = 2'd0;
          busy_next    = 1'b1;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        pending_next   = pending_reg | bus.refresh;
        dec_value_next = snap_reg[slot_reg];
        state_next     = CAPTURE;
      end
      CAPTURE: begin
        pending_next = pending_reg | bus.refresh;
        seg_we       = 1'b1;
        if (slot_reg == 2'd3) begin
          frame_done_next = 1'b1;
          state_next      = DONE;
        end else begin
          slot_next  = slot_reg + 2'd1;
          state_next = ISSUE;
        end
      end
      DONE: begin
        // A request seen here still queues the next frame behind one IDLE cycle.
        pending_next = pending_reg | bus.refresh;
        busy_next    = 1'b0;
        slot_next    = 2'd0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Overlay priority: blink wins outright (no DP), then dashes, then digits.
  always_comb begin
    cur_value  = snap_reg[slot_reg];
    pair_left  = bus.dec_left;
    pair_right = bus.dec_right;
    if (bus.blink_mask[slot_reg] && bus.blink_phase) begin
      pair_left  = 8'h00;
      pair_right = 8'h00;
    end else begin
      if (cur_value > 7'd99) begin
        pair_left  = 8'h40;
        pair_right = 8'h40;
      end else if (LZ_BLANK_MASK[slot_reg] && (cur_value < 7'd10)) begin
        pair_left = 8'h00;
      end
      if (DP_MASK[slot_reg]) begin
        pair_right[7] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    always_ff @(posedge hz100) begin
      if (!reset_n) begin
        snap_reg[gi] <= 7'd0;
      end else if (snap_load) begin
        snap_reg[gi] <= field[gi];
      end
    end

    always_ff @(posedge hz100) begin
      if (!reset_n) begin
        seg_slot_reg[gi] <= 16'h0000;
      end else if (seg_we && (slot_reg == 2'(gi))) begin
        seg_slot_reg[gi] <= {pair_left, pair_right};
      end
    end
  end

  always_comb begin
    seg_flat = 64'd0;
    for (int i = 0; i < 4; i++) begin
      seg_flat[16*i +: 16] = seg_slot_reg[i];
    end
  end

  assign bus.seg        = seg_flat;
  assign bus.dec_value  = dec_value_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;

endmodule
